// File: rtl/sam_spi_pkg.sv
// Shared definitions for the SAM D21 SPI responder: command codes, FSM states, CRC polynomial.
package sam_spi_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  localparam logic [7:0] CRC8_POLY  = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_STATUS,
    ST_DRAIN,
    ST_CRC
  } spiStateT;

endpackage

// File: rtl/sam_spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detect on the synchronised level.
module sam_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic asyncIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;

  // Reset to the pin's idle level so no spurious edge appears when reset is released
  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ <= {SYNC_STAGES{RESET_VAL}};
      prevQ <= RESET_VAL;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], asyncIn};
      prevQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign level = syncQ[SYNC_STAGES-1];
  assign rise  = level & ~prevQ;
  assign fall  = ~level & prevQ;

endmodule

// File: rtl/sam_spi_responder.sv
// SPI mode-0 responder turning SAM command frames into register-bus strobes, plus interrupt/status.
// Optional build macro SAM_SPI_CRC8_EN appends a CRC-8 byte to WRITE and READ frames.
module sam_spi_responder
  import sam_spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              irq_req,
  output logic              sam_int
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  logic sckLvl, sckRise, sckFall;
  logic csLvl, csRise, csFall;
  logic mosiLvl, mosiRise, mosiFall;
  logic unusedSigs;

  sam_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSck (
    .clk(clk), .reset(reset), .asyncIn(spi_sck),
    .level(sckLvl), .rise(sckRise), .fall(sckFall));
  sam_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncCs (
    .clk(clk), .reset(reset), .asyncIn(spi_cs_n),
    .level(csLvl), .rise(csRise), .fall(csFall));
  sam_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
    .clk(clk), .reset(reset), .asyncIn(spi_mosi),
    .level(mosiLvl), .rise(mosiRise), .fall(mosiFall));

  assign unusedSigs = ^{sckLvl, csRise, mosiRise, mosiFall};

  spiStateT          state;
  logic [2:0]        bitCnt;
  logic [BCW-1:0]    byteCnt;
  logic [6:0]        rxShift;
  logic [7:0]        rxByte;
  logic [7:0]        txShift;
  logic [DATA_W-1:0] wShift;
  logic [DATA_W-1:0] rdShift;
  logic              cmdRead;
  logic              rdVld_p1;
  logic              irqPending;
  logic              errSticky;
  logic              lastByte;
`ifdef SAM_SPI_CRC8_EN
  logic [7:0]        wrCrc;
  logic [7:0]        rdCrc;

  function automatic logic [7:0] crc8Upd(input logic [7:0] crcIn, input logic [7:0] dataIn);
    logic [7:0] c;
    c = crcIn ^ dataIn;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    return c;
  endfunction
`endif

  function automatic logic [DATA_W-1:0] shiftInByte(input logic [DATA_W-1:0] acc,
                                                    input logic [7:0] b);
    return (acc << 8) | DATA_W'(b);
  endfunction

  assign rxByte   = {rxShift, mosiLvl};
  assign lastByte = (byteCnt == BCW'(NBYTES - 1));
  assign spi_miso = txShift[7];
  assign sam_int  = irqPending;

  always_ff @(posedge clk) begin
    reg_wr <= 1'b0;
    reg_rd <= 1'b0;
    if (reset) begin
      state      <= ST_IDLE;
      bitCnt     <= '0;
      byteCnt    <= '0;
      txShift    <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      cmdRead    <= 1'b0;
      rdVld_p1   <= 1'b0;
      irqPending <= 1'b0;
      errSticky  <= 1'b0;
    end else begin
      // Stage p1: read data is valid the cycle after reg_rd
      rdVld_p1 <= reg_rd;
      if (csLvl) begin
        state   <= ST_IDLE;
        bitCnt  <= '0;
        byteCnt <= '0;
        txShift <= '0;
      end else if (state == ST_IDLE) begin
        if (csFall) state <= ST_CMD;
      end else begin
        // Shifting is skipped on the fall right after a byte boundary so a freshly loaded MSB survives
        if (sckFall && bitCnt != 3'd0) txShift <= {txShift[6:0], 1'b0};
        if (rdVld_p1 && state == ST_RDATA) begin
          txShift <= reg_rdata[DATA_W-1 -: 8];
          rdShift <= reg_rdata << 8;
`ifdef SAM_SPI_CRC8_EN
          rdCrc   <= crc8Upd(8'h00, reg_rdata[DATA_W-1 -: 8]);
`endif
        end
        if (sckRise) begin
          rxShift <= rxByte[6:0];
          bitCnt  <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            case (state)
              ST_CMD: begin
`ifdef SAM_SPI_CRC8_EN
                wrCrc <= crc8Upd(8'h00, rxByte);
`endif
                case (rxByte)
                  CMD_WRITE: begin cmdRead <= 1'b0; state <= ST_ADDR; end
                  CMD_READ:  begin cmdRead <= 1'b1; state <= ST_ADDR; end
                  CMD_STATUS: begin
                    txShift <= {irqPending, errSticky, 6'b0};
                    state   <= ST_STATUS;
                  end
                  default: begin errSticky <= 1'b1; state <= ST_DRAIN; end
                endcase
              end
              ST_ADDR: begin
                reg_addr <= ADDR_W'(rxByte);
                byteCnt  <= '0;
`ifdef SAM_SPI_CRC8_EN
                wrCrc    <= crc8Upd(wrCrc, rxByte);
`endif
                if (cmdRead) begin
                  reg_rd <= 1'b1;
                  state  <= ST_RDATA;
                end else begin
                  state  <= ST_WDATA;
                end
              end
              ST_WDATA: begin
                byteCnt <= byteCnt + BCW'(1);
                wShift  <= shiftInByte(wShift, rxByte);
`ifdef SAM_SPI_CRC8_EN
                wrCrc   <= crc8Upd(wrCrc, rxByte);
                if (lastByte) state <= ST_CRC;
`else
                if (lastByte) begin
                  reg_wdata <= shiftInByte(wShift, rxByte);
                  reg_wr    <= 1'b1;
                  state     <= ST_DRAIN;
                end
`endif
              end
              ST_RDATA: begin
                byteCnt <= byteCnt + BCW'(1);
                if (lastByte) begin
`ifdef SAM_SPI_CRC8_EN
                  txShift <= rdCrc;
                  state   <= ST_CRC;
`else
                  txShift <= '0;
                  state   <= ST_DRAIN;
`endif
                end else begin
                  txShift <= rdShift[DATA_W-1 -: 8];
                  rdShift <= rdShift << 8;
`ifdef SAM_SPI_CRC8_EN
                  rdCrc   <= crc8Upd(rdCrc, rdShift[DATA_W-1 -: 8]);
`endif
                end
              end
              ST_STATUS: begin
                irqPending <= 1'b0;
                errSticky  <= 1'b0;
                txShift    <= '0;
                state      <= ST_DRAIN;
              end
              ST_CRC: begin
`ifdef SAM_SPI_CRC8_EN
                if (!cmdRead) begin
                  if (rxByte == wrCrc) begin
                    reg_wdata <= wShift;
                    reg_wr    <= 1'b1;
                  end else begin
                    errSticky <= 1'b1;
                  end
                end
`endif
                txShift <= '0;
                state   <= ST_DRAIN;
              end
              default: txShift <= '0;
            endcase
          end
        end
      end
      // A new request in the same cycle as a STATUS clear must not be lost
      if (irq_req) irqPending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sam_spi_responder.sv
// Randomised frame-level bench for sam_spi_responder against a register-transaction reference model.
module tb_sam_spi_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              spi_sck = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              irq_req = 1'b0;
  logic [DATA_W-1:0] reg_rdata = '0;
  logic              spi_miso, reg_wr, reg_rd, sam_int;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;

  sam_spi_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_req(irq_req), .sam_int(sam_int));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wrCount = 0;
  int rdCount = 0;
  logic [ADDR_W-1:0] lastWrAddr = '0;
  logic [ADDR_W-1:0] lastRdAddr = '0;
  logic [DATA_W-1:0] lastWdata = '0;
  bit modelIrq = 1'b0;
  bit modelErr = 1'b0;
  logic [7:0] txBuf [16];
  logic [7:0] rxBuf [16];

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr) begin wrCount++; lastWrAddr = reg_addr; lastWdata = reg_wdata; end
      if (reg_rd) begin rdCount++; lastRdAddr = reg_addr; end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // SCK half period of 4 clk gives the 8x oversampling margin
  task automatic spiByte(input logic [7:0] txb, input bit irqAtEnd, output logic [7:0] rxb);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = txb[i];
      repeat (4) @(negedge clk);
      rxb[i] = spi_miso;
      spi_sck = 1'b1;
      if (irqAtEnd && i == 0) begin
        repeat (2) @(negedge clk);
        irq_req = 1'b1;
        @(negedge clk);
        irq_req = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic runFrame(input int n, input bit irqAtEnd);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      logic [7:0] r;
      spiByte(txBuf[b], irqAtEnd && (b == n - 1), r);
      rxBuf[b] = r;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [DATA_W-1:0] data, input bit crcGood);
    int n, wrBefore;
    logic [7:0] crc, orAll;
    wrBefore = wrCount;
    txBuf[0] = 8'h01; txBuf[1] = addr;
    for (int k = 0; k < NB; k++) txBuf[2 + k] = data[DATA_W - 1 - 8 * k -: 8];
    n = 2 + NB;
`ifdef SAM_SPI_CRC8_EN
    crc = 8'h00;
    for (int k = 0; k < n; k++) crc = crcStep(crc, txBuf[k]);
    txBuf[n] = crcGood ? crc : (crc ^ 8'h5A);
    n++;
`else
    crc = 8'h00;
    crcGood = 1'b1;
`endif
    runFrame(n, 1'b0);
    orAll = 8'h00;
    for (int k = 0; k < n; k++) orAll |= rxBuf[k];
    chkEq("wr_miso_zero", {24'h0, orAll}, 32'h0);
    chkEq("wr_count", wrCount - wrBefore, crcGood ? 32'd1 : 32'd0);
    if (crcGood) begin
      chkEq("wr_addr", {24'h0, lastWrAddr}, {24'h0, addr});
      chkEq("wr_data", lastWdata, data);
    end else begin
      modelErr = 1'b1;
    end
    chkEq("wr_sam_int", {31'h0, sam_int}, {31'h0, modelIrq});
  endtask

  task automatic doRead(input logic [7:0] addr, input logic [DATA_W-1:0] data);
    int n, rdBefore, wrBefore;
    logic [7:0] crc;
    rdBefore = rdCount; wrBefore = wrCount;
    reg_rdata = data;
    txBuf[0] = 8'h02; txBuf[1] = addr;
    for (int k = 0; k < NB + 1; k++) txBuf[2 + k] = 8'($urandom);
`ifdef SAM_SPI_CRC8_EN
    n = 3 + NB;
`else
    n = 2 + NB;
`endif
    runFrame(n, 1'b0);
    crc = 8'h00;
    for (int k = 0; k < NB; k++) begin
      chkEq($sformatf("rd_byte%0d", k), {24'h0, rxBuf[2 + k]}, {24'h0, data[DATA_W - 1 - 8 * k -: 8]});
      crc = crcStep(crc, data[DATA_W - 1 - 8 * k -: 8]);
    end
`ifdef SAM_SPI_CRC8_EN
    chkEq("rd_crc", {24'h0, rxBuf[2 + NB]}, {24'h0, crc});
`endif
    chkEq("rd_count", rdCount - rdBefore, 32'd1);
    chkEq("rd_addr", {24'h0, lastRdAddr}, {24'h0, addr});
    chkEq("rd_no_wr", wrCount - wrBefore, 32'd0);
  endtask

  task automatic doStatus(input bit irqAtEnd);
    logic [7:0] exp;
    exp = {modelIrq, modelErr, 6'b0};
    txBuf[0] = 8'h03; txBuf[1] = 8'($urandom);
    runFrame(2, irqAtEnd);
    chkEq("status_byte", {24'h0, rxBuf[1]}, {24'h0, exp});
    modelErr = 1'b0;
    modelIrq = irqAtEnd;
    chkEq("status_sam_int", {31'h0, sam_int}, {31'h0, modelIrq});
  endtask

  task automatic doUnknown(input logic [7:0] cmd);
    int wrBefore, rdBefore;
    wrBefore = wrCount; rdBefore = rdCount;
    txBuf[0] = cmd; txBuf[1] = 8'($urandom); txBuf[2] = 8'($urandom);
    runFrame(3, 1'b0);
    chkEq("unk_miso", {16'h0, rxBuf[1], rxBuf[2]}, 32'h0);
    chkEq("unk_no_strobe", (wrCount - wrBefore) + (rdCount - rdBefore), 32'd0);
    modelErr = 1'b1;
  endtask

  task automatic doAbort(input logic [7:0] addr, input int k);
    int wrBefore;
    wrBefore = wrCount;
    txBuf[0] = 8'h01; txBuf[1] = addr;
    for (int i = 0; i < k; i++) txBuf[2 + i] = 8'($urandom);
    runFrame(2 + k, 1'b0);
    chkEq("abort_no_wr", wrCount - wrBefore, 32'd0);
  endtask

  task automatic pulseIrq();
    irq_req = 1'b1;
    @(negedge clk);
    irq_req = 1'b0;
    modelIrq = 1'b1;
    repeat (2) @(negedge clk);
    chkEq("irq_sam_int", {31'h0, sam_int}, 32'h1);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chkEq("rst_outs", {27'h0, spi_miso, reg_wr, reg_rd, sam_int, 1'b0}, 32'h0);
    chkEq("rst_addr_data", {24'h0, reg_addr} | reg_wdata, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    doWrite(8'h10, 32'hDEADBEEF, 1'b1);
    doRead(8'h22, 32'h12345678);
    pulseIrq();
    doStatus(1'b0);
    doUnknown(8'h7F);
    doStatus(1'b0);
    doAbort(8'h10, 1);
    doWrite(8'h10, 32'hCAFEF00D, 1'b1);
    pulseIrq();
    doStatus(1'b1);
    doStatus(1'b0);
`ifdef SAM_SPI_CRC8_EN
    doWrite(8'h33, 32'h01020304, 1'b0);
    doStatus(1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 5))
        0: doWrite(8'($urandom), DATA_W'($urandom), 1'b1);
        1: doRead(8'($urandom), DATA_W'($urandom));
        2: doStatus(1'b0);
        3: begin
          logic [7:0] c;
          do c = 8'($urandom); while (c >= 8'h01 && c <= 8'h03);
          doUnknown(c);
        end
        4: doAbort(8'($urandom), $urandom_range(0, NB - 1));
        default: pulseIrq();
      endcase
    end
    doStatus(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
